// File: rtl/bp_me_bedrock_scratch_responder_pkg.sv
// Shared types for the BedRock scratchpad responder.
//   - BedRock memory message type and size enums
//   - Memory header struct: {payload, size, addr, subop, msg_type}
//   - Responder FSM state enum
//   - Helper that replicates a sub-dword value across the 64-bit fill bus
package bp_me_bedrock_scratch_responder_pkg;

  localparam int paddr_width_gp        = 40;
  localparam int bedrock_fill_width_gp = 64;
  localparam int payload_width_gp      = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    logic [3:0]                  subop;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic {e_ready, e_resp} bp_me_scratch_state_e;

  // Replicate the low (1<<size) bytes of d across all 64 bits.
  function automatic logic [63:0] bedrock_replicate(input logic [63:0] d,
                                                    input bp_bedrock_msg_size_e size);
    case (size)
      e_bedrock_msg_size_1: return {8{d[7:0]}};
      e_bedrock_msg_size_2: return {4{d[15:0]}};
      e_bedrock_msg_size_4: return {2{d[31:0]}};
      default:              return d;
    endcase
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write enables.
//   clk_i         clock
//   v_i / w_i     access valid / write (read when w_i=0)
//   addr_i        dword index
//   data_i        write data
//   write_mask_i  one bit per byte lane
//   data_o        read data; updates only on a read, holds otherwise
module bsg_mem_1rw_sync_mask_write_byte
  #(parameter  int els_p        = 512
  , parameter  int data_width_p = 64
  , localparam int lg_els_lp    = $clog2(els_p)
  , localparam int lanes_lp     = data_width_p / 8
  )
  (input  logic                    clk_i
  , input  logic                    v_i
  , input  logic                    w_i
  , input  logic [lg_els_lp-1:0]    addr_i
  , input  logic [data_width_p-1:0] data_i
  , input  logic [lanes_lp-1:0]     write_mask_i
  , output logic [data_width_p-1:0] data_o
  );

  // Each byte lane is its own array so lane writes never share a driver.
  for (genvar g = 0; g < lanes_lp; g++) begin : lane
    logic [7:0] mem_q [els_p];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (v_i & w_i & write_mask_i[g])
        mem_q[addr_i] <= data_i[g*8 +: 8];
      if (v_i & ~w_i)
        rd_q <= mem_q[addr_i];
    end

    assign data_o[g*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/bp_me_bedrock_scratch_responder.sv
// BedRock memory responder backed by a byte-maskable scratchpad.
// Accepts one uncached single-beat read or write on mem_fwd, returns exactly
// one mem_rev message echoing the request header.
//   clk_i, reset_i             clock, synchronous active-high reset
//   mem_fwd_header_i/data_i    request header and replicated write data
//   mem_fwd_v_i/ready_and_o    request handshake
//   mem_rev_header_o/data_o    response header and replicated read data
//   mem_rev_v_o/ready_and_i    response handshake
//   err_o                      sticky error flag (cleared by reset only)
module bp_me_bedrock_scratch_responder
  import bp_me_bedrock_scratch_responder_pkg::*;
  #(parameter  int                        els_p       = 512
  , parameter  logic [paddr_width_gp-1:0] base_addr_p = 40'h00_0011_0000
  , localparam int                        lg_els_lp   = $clog2(els_p)
  )
  (input  logic                             clk_i
  , input  logic                             reset_i
  , input  logic [mem_header_width_gp-1:0]   mem_fwd_header_i
  , input  logic [bedrock_fill_width_gp-1:0] mem_fwd_data_i
  , input  logic                             mem_fwd_v_i
  , output logic                             mem_fwd_ready_and_o
  , output logic [mem_header_width_gp-1:0]   mem_rev_header_o
  , output logic [bedrock_fill_width_gp-1:0] mem_rev_data_o
  , output logic                             mem_rev_v_o
  , input  logic                             mem_rev_ready_and_i
  , output logic                             err_o
  );

  localparam logic [paddr_width_gp-1:0] span_lp = paddr_width_gp'(els_p * 8);

  bp_bedrock_mem_header_s fwd_hdr, rev_hdr_q;
  bp_me_scratch_state_e   state_q;
  bp_bedrock_msg_size_e   size_q;
  logic [2:0]             byte_q;
  logic                   rev_v_q, err_q, req_err_q, wr_q;

  assign fwd_hdr = bp_bedrock_mem_header_s'(mem_fwd_header_i);

  // Decode
  logic [paddr_width_gp-1:0] off;
  logic [lg_els_lp-1:0]      idx;
  logic [2:0]                byte_off, align_m;
  logic [7:0]                mask_base, byte_mask;
  logic                      is_rd, is_wr, range_err, size_err, misalign, req_err;

  assign off       = fwd_hdr.addr - base_addr_p;  // addr < base wraps to huge off
  assign idx       = off[3 +: lg_els_lp];
  assign byte_off  = off[2:0];
  assign is_rd     = (fwd_hdr.msg_type == e_bedrock_mem_uc_rd);
  assign is_wr     = (fwd_hdr.msg_type == e_bedrock_mem_uc_wr);
  assign range_err = (off >= span_lp);
  assign size_err  = (fwd_hdr.size > e_bedrock_msg_size_8);

  always_comb begin
    align_m   = 3'b111;
    mask_base = 8'hFF;
    case (fwd_hdr.size)
      e_bedrock_msg_size_1: begin align_m = 3'b000; mask_base = 8'h01; end
      e_bedrock_msg_size_2: begin align_m = 3'b001; mask_base = 8'h03; end
      e_bedrock_msg_size_4: begin align_m = 3'b011; mask_base = 8'h0F; end
      default:              begin align_m = 3'b111; mask_base = 8'hFF; end
    endcase
  end

  assign misalign  = |(byte_off & align_m);
  assign req_err   = range_err | size_err | misalign | ~(is_rd | is_wr);
  assign byte_mask = mask_base << byte_off;

  // Handshake; ready is forced low during reset.
  logic fwd_hs;
  assign mem_fwd_ready_and_o = (state_q == e_ready) & ~reset_i;
  assign fwd_hs              = mem_fwd_v_i & mem_fwd_ready_and_o;

  // Storage. The read result is held in e_resp since no access can start there.
  logic [bedrock_fill_width_gp-1:0] mem_data;

  bsg_mem_1rw_sync_mask_write_byte
    #(.els_p(els_p), .data_width_p(bedrock_fill_width_gp))
    mem
     (.clk_i        (clk_i)
     ,.v_i          (fwd_hs & ~req_err)
     ,.w_i          (is_wr)
     ,.addr_i       (idx)
     ,.data_i       (mem_fwd_data_i)
     ,.write_mask_i (byte_mask)
     ,.data_o       (mem_data)
     );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      rev_v_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        e_ready:
          if (fwd_hs) begin
            rev_hdr_q <= fwd_hdr;
            size_q    <= fwd_hdr.size;
            byte_q    <= byte_off;
            req_err_q <= req_err;
            wr_q      <= is_wr;
            err_q     <= err_q | req_err;
            rev_v_q   <= 1'b1;
            state_q   <= e_resp;
          end
        e_resp:
          if (mem_rev_ready_and_i) begin
            rev_v_q <= 1'b0;
            state_q <= e_ready;
          end
        default: state_q <= e_ready;
      endcase
    end
  end

  logic [bedrock_fill_width_gp-1:0] rd_shift;
  assign rd_shift = mem_data >> {byte_q, 3'b000};

  assign mem_rev_header_o = rev_hdr_q;
  assign mem_rev_data_o   = (req_err_q | wr_q) ? '0 : bedrock_replicate(rd_shift, size_q);
  assign mem_rev_v_o      = rev_v_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_bp_me_bedrock_scratch_responder.sv
module tb_bp_me_bedrock_scratch_responder;
  import bp_me_bedrock_scratch_responder_pkg::*;

  localparam logic [39:0] BASE = 40'h00_0011_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [mem_header_width_gp-1:0] fwd_hdr, rev_hdr;
  logic [63:0] fwd_data, rev_data;
  logic        fwd_v, fwd_ready, rev_v, rev_ready, err;

  always #5 clk = ~clk;

  bp_me_bedrock_scratch_responder #(.els_p(512), .base_addr_p(BASE)) dut
    (.clk_i(clk), .reset_i(reset)
    ,.mem_fwd_header_i(fwd_hdr), .mem_fwd_data_i(fwd_data)
    ,.mem_fwd_v_i(fwd_v), .mem_fwd_ready_and_o(fwd_ready)
    ,.mem_rev_header_o(rev_hdr), .mem_rev_data_o(rev_data)
    ,.mem_rev_v_o(rev_v), .mem_rev_ready_and_i(rev_ready)
    ,.err_o(err));

  int checks = 0, errors = 0;
  int fwd_hs = 0, rev_hs = 0;
  logic [15:0] pl = 16'h0;
  logic [63:0] model [16];

  always @(posedge clk) if (!reset) begin
    if (fwd_v && fwd_ready) fwd_hs <= fwd_hs + 1;
    if (rev_v && rev_ready) rev_hs <= rev_hs + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bp_bedrock_mem_header_s mk(input bp_bedrock_mem_type_e t, input logic [39:0] a,
                                                input bp_bedrock_msg_size_e s, input logic [15:0] p);
    bp_bedrock_mem_header_s h;
    h.payload = p; h.size = s; h.addr = a; h.subop = 4'h0; h.msg_type = t;
    return h;
  endfunction

  // One full request/response; rev ready withheld for 'delay' cycles, with
  // the response checked against the expected values every held cycle.
  task automatic xact(input string tag, input bp_bedrock_mem_header_s h, input logic [63:0] wd,
                      input logic [63:0] exp, input int delay);
    int n = 0;
    @(negedge clk);
    fwd_hdr = h; fwd_data = wd; fwd_v = 1'b1;
    while (!fwd_ready && n < 20) begin @(negedge clk); n++; end
    if (!fwd_ready) chk({tag, "_fwd_ready_timeout"}, 0, 1);
    @(posedge clk); #1 fwd_v = 1'b0;
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      chk({tag, "_rev_v"}, rev_v, 1'b1);
      chk({tag, "_rev_hdr"}, rev_hdr, h);
      chk({tag, "_rev_data"}, rev_data, exp);
      chk({tag, "_fwd_ready_busy"}, fwd_ready, 1'b0);
    end
    rev_ready = 1'b1;
    @(posedge clk); #1 rev_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rev_v_drop"}, rev_v, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_fwd_ready", fwd_ready, 1'b0);
    chk("reset_rev_v", rev_v, 1'b0);
    chk("reset_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_fwd_ready", fwd_ready, 1'b1);
  endtask

  initial begin
    int hs0;
    reset = 1'b1; fwd_v = 1'b0; rev_ready = 1'b0; fwd_hdr = '0; fwd_data = '0;
    do_reset();

    // Dword round trip and sub-word write / reads
    xact("wr8", mk(e_bedrock_mem_uc_wr, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0101),
         64'h1122334455667788, 64'h0, 0);
    xact("rd8", mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0102),
         64'h0, 64'h1122334455667788, 0);
    xact("wr1", mk(e_bedrock_mem_uc_wr, BASE + 40'h13, e_bedrock_msg_size_1, 16'h0103),
         64'hABABABABABABABAB, 64'h0, 0);
    xact("rd8_after_wr1", mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0104),
         64'h0, 64'h11223344AB667788, 0);
    xact("rd2", mk(e_bedrock_mem_uc_rd, BASE + 40'h12, e_bedrock_msg_size_2, 16'h0105),
         64'h0, 64'hAB66AB66AB66AB66, 0);
    chk("err_clean", err, 1'b0);

    // Backpressure: 5 cycles of held response, exactly one response
    hs0 = rev_hs;
    xact("bp", mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0106),
         64'h0, 64'h11223344AB667788, 5);
    chk("bp_one_resp", rev_hs - hs0, 1);

    // Seed model region dwords 16..31, then random traffic
    for (int i = 0; i < 16; i++) begin
      model[i] = {$urandom, $urandom};
      pl++;
      xact("seed", mk(e_bedrock_mem_uc_wr, BASE + 40'(((16 + i) * 8)), e_bedrock_msg_size_8, pl),
           model[i], 64'h0, $urandom_range(0, 1));
    end
    for (int k = 0; k < 100; k++) begin
      int idx, sz, nb, bo;
      logic [63:0] raw, wd, exp;
      logic [39:0] a;
      idx = $urandom_range(0, 15);
      sz  = $urandom_range(0, 3);
      nb  = 1 << sz;
      bo  = $urandom_range(0, 7) & ~(nb - 1);
      a   = BASE + 40'((16 + idx) * 8 + bo);
      raw = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) wd[i*8 +: 8] = raw[(i % nb)*8 +: 8];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pl++;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < nb; i++) model[idx][(bo + i)*8 +: 8] = wd[(bo + i)*8 +: 8];
        xact("rand_wr", mk(e_bedrock_mem_uc_wr, a, bp_bedrock_msg_size_e'(sz), pl), wd, 64'h0,
             $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < 8; i++) exp[i*8 +: 8] = model[idx][(bo + (i % nb))*8 +: 8];
        xact("rand_rd", mk(e_bedrock_mem_uc_rd, a, bp_bedrock_msg_size_e'(sz), pl), 64'h0, exp,
             $urandom_range(0, 3));
      end
    end
    chk("rand_err_clean", err, 1'b0);
    chk("one_rev_per_fwd", rev_hs, fwd_hs);

    // Errors, each from a clean err_o
    xact("wr_dw0", mk(e_bedrock_mem_uc_wr, BASE, e_bedrock_msg_size_8, 16'h0201),
         64'hDEADBEEFCAFEF00D, 64'h0, 0);
    xact("err_range", mk(e_bedrock_mem_uc_rd, BASE + 40'h1000, e_bedrock_msg_size_8, 16'h0202),
         64'h0, 64'h0, 0);
    chk("err_range_flag", err, 1'b1);
    xact("err_below", mk(e_bedrock_mem_uc_rd, BASE - 40'h8, e_bedrock_msg_size_8, 16'h0203),
         64'h0, 64'h0, 0);
    chk("err_sticky", err, 1'b1);

    do_reset();
    xact("err_misalign", mk(e_bedrock_mem_uc_wr, BASE + 40'h2, e_bedrock_msg_size_4, 16'h0204),
         64'h5555555555555555, 64'h0, 0);
    chk("err_misalign_flag", err, 1'b1);
    xact("chk_dw0", mk(e_bedrock_mem_uc_rd, BASE, e_bedrock_msg_size_8, 16'h0205),
         64'h0, 64'hDEADBEEFCAFEF00D, 0);
    chk("err_misalign_stays", err, 1'b1);

    do_reset();
    xact("err_cached", mk(e_bedrock_mem_wr, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0206),
         64'hFFFFFFFFFFFFFFFF, 64'h0, 0);
    chk("err_cached_flag", err, 1'b1);
    xact("chk_dw2a", mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0207),
         64'h0, 64'h11223344AB667788, 0);

    do_reset();
    xact("err_size64", mk(e_bedrock_mem_uc_wr, BASE + 40'h10, e_bedrock_msg_size_64, 16'h0208),
         64'h0, 64'h0, 0);
    chk("err_size64_flag", err, 1'b1);
    xact("chk_dw2b", mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0209),
         64'h0, 64'h11223344AB667788, 0);
    chk("err_size64_stays", err, 1'b1);

    // Reset while a response is pending
    @(negedge clk);
    fwd_hdr = mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0300);
    fwd_v = 1'b1;
    @(posedge clk); #1 fwd_v = 1'b0;
    @(negedge clk);
    chk("midrst_pending", rev_v, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rev_v", rev_v, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_fwd_ready", fwd_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", fwd_ready, 1'b1);
    xact("midrst_rd", mk(e_bedrock_mem_uc_rd, BASE + 40'h10, e_bedrock_msg_size_8, 16'h0301),
         64'h0, 64'h11223344AB667788, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
